// File: rtl/wb_load_ctrl_if.sv
// wb_load_ctrl_if: data-side SRAM-like bus between the load/store controller
// (master) and the memory system (slave).
//   data_req     master->slave  request valid
//   data_wr      master->slave  1 = write, 0 = read
//   data_size    master->slave  0 = byte, 1 = half, 2 = word
//   data_addr    master->slave  byte address
//   data_wdata   master->slave  write data
//   data_addr_ok slave->master  request accepted this cycle
//   data_data_ok slave->master  response valid this cycle (in request order)
//   data_rdata   slave->master  read data
interface wb_load_ctrl_if;
    localparam int unsigned DW = 32;

    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [DW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/wb_load_ctrl.sv
// wb_load_ctrl: data-side bus controller between the MEM-stage request and
// the WB-stage load-data path. Issues MEM requests on the bus, tracks
// outstanding transactions in order, drops store and flushed responses and
// buffers returned load data until WB accepts it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_req/wr/size/addr/wdata  MEM-stage access (held while mem_stall)
//   mem_stall       MEM must hold its request this cycle
//   flush           kill all in-flight accesses and buffered load data
//   bus             wb_load_ctrl_if.master data bus
//   wb_ready        WB consumes wb_rdata this cycle
//   wb_rdata_valid  wb_rdata holds valid load data
//   wb_rdata        oldest buffered load data
//   idle            nothing outstanding and return buffer empty
//
// Optional feature, macro WB_RDATA_BYPASS_EN: a read response arriving while
// the return buffer is empty is presented on wb_rdata in the same cycle.
module wb_load_ctrl #(
    parameter int unsigned MAX_OUT    = 2,
    parameter int unsigned RBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req,
    input  logic                 mem_wr,
    input  logic [1:0]           mem_size,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    output logic                 mem_stall,
    input  logic                 flush,
    wb_load_ctrl_if.master       bus,
    input  logic                 wb_ready,
    output logic                 wb_rdata_valid,
    output logic [31:0]          wb_rdata,
    output logic                 idle
);
    localparam int unsigned DW     = 32;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned RCNT_W = $clog2(RBUF_DEPTH + 1);
    localparam int unsigned TPTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned RPTR_W = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

    // Outstanding-transaction tag FIFO
    logic [CNT_W-1:0]   cnt;
    logic [TPTR_W-1:0]  t_head;
    logic [TPTR_W-1:0]  t_tail;
    logic [MAX_OUT-1:0] tag_wr;
    logic [MAX_OUT-1:0] tag_kill;

    // Return-data buffer
    logic [DW-1:0]      rbuf [RBUF_DEPTH];
    logic [RCNT_W-1:0]  rbuf_cnt;
    logic [RPTR_W-1:0]  r_head;
    logic [RPTR_W-1:0]  r_tail;

    logic can_issue;
    logic accept;
    logic rsp_pop;
    logic rsp_keep;
    logic rbuf_push;
    logic rbuf_pop;

    function automatic logic [TPTR_W-1:0] t_inc(input logic [TPTR_W-1:0] p);
        return (p == TPTR_W'(MAX_OUT - 1)) ? '0 : p + TPTR_W'(1);
    endfunction

    function automatic logic [RPTR_W-1:0] r_inc(input logic [RPTR_W-1:0] p);
        return (p == RPTR_W'(RBUF_DEPTH - 1)) ? '0 : p + RPTR_W'(1);
    endfunction

    // Bus request side. Loads also reserve a return-buffer slot so the buffer
    // can never overflow regardless of how long WB stalls.
    always_comb begin
        can_issue = (cnt < CNT_W'(MAX_OUT)) &&
                    (mem_wr || ((32'(cnt) + 32'(rbuf_cnt)) < RBUF_DEPTH));
        bus.data_req   = mem_req && !flush && can_issue;
        bus.data_wr    = mem_wr;
        bus.data_size  = mem_size;
        bus.data_addr  = mem_addr;
        bus.data_wdata = mem_wdata;
        accept         = bus.data_req && bus.data_addr_ok;
        mem_stall      = mem_req && !flush && !accept;
        idle           = (cnt == '0) && (rbuf_cnt == '0);
    end

    // Response routing: a flush in the same cycle also kills the popped head.
    always_comb begin
        rsp_pop  = bus.data_data_ok && (cnt != '0);
        rsp_keep = rsp_pop && !tag_wr[t_head] && !tag_kill[t_head] && !flush;
        rbuf_pop = (rbuf_cnt != '0) && wb_ready;
`ifdef WB_RDATA_BYPASS_EN
        if (rsp_keep && (rbuf_cnt == '0)) begin
            wb_rdata_valid = 1'b1;
            wb_rdata       = bus.data_rdata;
            rbuf_push      = !wb_ready;
        end else begin
            wb_rdata_valid = (rbuf_cnt != '0);
            wb_rdata       = rbuf[r_head];
            rbuf_push      = rsp_keep;
        end
`else
        wb_rdata_valid = (rbuf_cnt != '0);
        wb_rdata       = rbuf[r_head];
        rbuf_push      = rsp_keep;
`endif
    end

    // Tag FIFO and outstanding count; cnt survives flush so killed
    // responses still drain from the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            t_head   <= '0;
            t_tail   <= '0;
            tag_wr   <= '0;
            tag_kill <= '0;
        end else begin
            if (rsp_pop) begin
                t_head <= t_inc(t_head);
            end
            if (accept) begin
                tag_wr[t_tail]   <= mem_wr;
                tag_kill[t_tail] <= 1'b0;
                t_tail           <= t_inc(t_tail);
            end
            if (flush) begin
                tag_kill <= '1;
            end
            if (accept && !rsp_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!accept && rsp_pop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Circular return buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf_cnt <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            for (int i = 0; i < int'(RBUF_DEPTH); i++) begin
                rbuf[i] <= '0;
            end
        end else if (flush) begin
            rbuf_cnt <= '0;
            r_head   <= '0;
            r_tail   <= '0;
        end else begin
            if (rbuf_push) begin
                rbuf[r_tail] <= bus.data_rdata;
                r_tail       <= r_inc(r_tail);
            end
            if (rbuf_pop) begin
                r_head <= r_inc(r_head);
            end
            if (rbuf_push && !rbuf_pop) begin
                rbuf_cnt <= rbuf_cnt + RCNT_W'(1);
            end else if (!rbuf_push && rbuf_pop) begin
                rbuf_cnt <= rbuf_cnt - RCNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is ignored; flag it in simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.data_data_ok && (cnt == '0)))
                else $warning("wb_load_ctrl: data_data_ok with no outstanding transaction ignored");
        end
    end
`endif
endmodule

// File: tb/tb_wb_load_ctrl.sv
// Testbench for wb_load_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based
// model of the outstanding transactions and the return buffer.
module tb_wb_load_ctrl;
    localparam int MAX_OUT    = 2;
    localparam int RBUF_DEPTH = 2;
`ifdef WB_RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        flush;
    logic        wb_ready;
    logic        wb_rdata_valid;
    logic [31:0] wb_rdata;
    logic        idle;

    wb_load_ctrl_if bus ();

    wb_load_ctrl #(.MAX_OUT(MAX_OUT), .RBUF_DEPTH(RBUF_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_stall      (mem_stall),
        .flush          (flush),
        .bus            (bus),
        .wb_ready       (wb_ready),
        .wb_rdata_valid (wb_rdata_valid),
        .wb_rdata       (wb_rdata),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic wr;
        logic kill;
    } tag_t;

    tag_t        tagq [$];   // accepted, unanswered transactions, oldest first
    logic [31:0] rq   [$];   // buffered load data, oldest first

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: inputs change just after posedge, so at negedge they
    // are the values the next posedge samples. Check, then advance the model.
    always @(negedge clk) begin
        int   c;
        int   rc;
        logic can;
        logic e_req;
        logic acc;
        logic e_stall;
        logic pop;
        logic keep;
        logic byp;
        logic e_valid;
        tag_t h;
        if (rst) begin
            tagq.delete();
            rq.delete();
        end else begin
            c       = tagq.size();
            rc      = rq.size();
            can     = (c < MAX_OUT) && (mem_wr || (c + rc < RBUF_DEPTH));
            e_req   = mem_req && !flush && can;
            acc     = e_req && bus.data_addr_ok;
            e_stall = mem_req && !flush && !acc;
            pop     = bus.data_data_ok && (c != 0);
            h       = pop ? tagq[0] : '0;
            keep    = pop && !h.wr && !h.kill && !flush;
            byp     = BYP && (rc == 0) && keep;
            e_valid = (rc != 0) || byp;

            chk1 ("data_req", bus.data_req, e_req);
            chk1 ("mem_stall", mem_stall, e_stall);
            chk1 ("idle", idle, (c == 0) && (rc == 0));
            chk1 ("wb_rdata_valid", wb_rdata_valid, e_valid);
            chk32("data_addr", bus.data_addr, mem_addr);
            chk32("data_wdata", bus.data_wdata, mem_wdata);
            chk1 ("data_wr", bus.data_wr, mem_wr);
            chk32("data_size", 32'(bus.data_size), 32'(mem_size));
            if (e_valid) begin
                chk32("wb_rdata", wb_rdata, byp ? bus.data_rdata : rq[0]);
            end

            if (pop) void'(tagq.pop_front());
            if (flush) begin
                foreach (tagq[i]) tagq[i].kill = 1'b1;
            end
            if (acc) tagq.push_back('{wr: mem_wr, kill: 1'b0});
            if (flush) begin
                rq.delete();
            end else if (byp) begin
                if (!wb_ready) rq.push_back(bus.data_rdata);
            end else begin
                if (e_valid && wb_ready) void'(rq.pop_front());
                if (keep) rq.push_back(bus.data_rdata);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mem_req = 1'b0; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = '0; mem_wdata = '0;
        flush = 1'b0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    endtask

    // Answer everything outstanding and empty the buffer, with a cycle bound.
    task automatic drain();
        int k;
        quiet();
        wb_ready = 1'b1;
        k = 0;
        while ((tagq.size() != 0 || rq.size() != 0 || !idle) && k < 50) begin
            bus.data_data_ok = (tagq.size() != 0);
            bus.data_rdata   = $urandom;
            nxt();
            k++;
        end
        bus.data_data_ok = 1'b0;
        #1;
        chk1("drain_idle", idle, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_ready = 1'b0;
        quiet();
        #1;
        chk1 ("rst_data_req", bus.data_req, 1'b0);
        chk1 ("rst_valid", wb_rdata_valid, 1'b0);
        chk1 ("rst_stall", mem_stall, 1'b0);
        chk1 ("rst_idle", idle, 1'b1);
        chk32("rst_rdata", wb_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single load, data_ok two cycles after accept
        nxt();
        mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h8000_1000;
        bus.data_addr_ok = 1'b1; wb_ready = 1'b1;
        #1;
        chk1 ("t1_req", bus.data_req, 1'b1);
        chk1 ("t1_stall", mem_stall, 1'b0);
        chk32("t1_addr", bus.data_addr, 32'h8000_1000);
        nxt();
        mem_req = 1'b0; bus.data_addr_ok = 1'b0;
        #1 chk1("t1_busy", idle, 1'b0);
        nxt();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        #1;
        chk1 ("t1_valid_n", wb_rdata_valid, BYP);
        chk32("t1_rdata_n", wb_rdata, BYP ? 32'hDEAD_BEEF : 32'h0);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t1_valid_n1", wb_rdata_valid, !BYP);
        chk32("t1_rdata_n1", wb_rdata, BYP ? 32'h0 : 32'hDEAD_BEEF);
        chk1 ("t1_idle_n1", idle, BYP);
        nxt();
        #1;
        chk1 ("t1_valid_end", wb_rdata_valid, 1'b0);
        chk1 ("t1_idle_end", idle, 1'b1);

        // Store then load back-to-back; only the load data reaches WB
        nxt();
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h8000_2000; mem_wdata = 32'h1234_5678;
        bus.data_addr_ok = 1'b1;
        #1;
        chk1 ("t2_wr", bus.data_wr, 1'b1);
        chk32("t2_wdata", bus.data_wdata, 32'h1234_5678);
        nxt();
        mem_wr = 1'b0;
        #1 chk1("t2_req_ld", bus.data_req, 1'b1);
        nxt();
        mem_req = 1'b0; bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
        #1 chk1("t2_store_drop", wb_rdata_valid, 1'b0);
        nxt();
        bus.data_rdata = 32'h2222_2222;
        #1;
        chk1 ("t2_valid_n", wb_rdata_valid, BYP);
        chk32("t2_rdata_n", wb_rdata, BYP ? 32'h2222_2222 : 32'h0);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t2_valid_n1", wb_rdata_valid, !BYP);
        chk32("t2_rdata_n1", wb_rdata, BYP ? 32'h0 : 32'h2222_2222);
        nxt();
        #1 chk1("t2_idle", idle, 1'b1);

        // Three loads with MAX_OUT=2: third is held until a slot frees
        nxt();
        mem_req = 1'b1; mem_wr = 1'b0; bus.data_addr_ok = 1'b1;
        nxt();
        nxt();
        #1;
        chk1 ("t3_req_blk", bus.data_req, 1'b0);
        chk1 ("t3_stall", mem_stall, 1'b1);
        nxt();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h3333_3333;
        #1 chk1("t3_stall_dok", mem_stall, 1'b1);
        nxt();
        bus.data_data_ok = 1'b0;
        #1 chk1("t3_req_after", bus.data_req, BYP);
        mem_req = 1'b0;
        #1;
        drain();

        // Flush kills two outstanding loads
        nxt();
        mem_req = 1'b1; mem_wr = 1'b0; bus.data_addr_ok = 1'b1;
        nxt();
        nxt();
        flush = 1'b1;
        #1;
        chk1 ("t4_flush_req", bus.data_req, 1'b0);
        chk1 ("t4_flush_stall", mem_stall, 1'b0);
        nxt();
        quiet();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hAAAA_0000;
        #1 chk1("t4_valid_a", wb_rdata_valid, 1'b0);
        nxt();
        bus.data_rdata = 32'hBBBB_0000;
        #1 chk1("t4_valid_b", wb_rdata_valid, 1'b0);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t4_valid_end", wb_rdata_valid, 1'b0);
        chk1 ("t4_idle", idle, 1'b1);

        // WB stalled: buffer fills, issue blocked, then drains in order
        wb_ready = 1'b0;
        nxt();
        mem_req = 1'b1; bus.data_addr_ok = 1'b1;
        nxt();
        nxt();
        mem_req = 1'b0; bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1;
        nxt();
        bus.data_rdata = 32'h2;
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t5_valid", wb_rdata_valid, 1'b1);
        chk32("t5_first", wb_rdata, 32'h1);
        mem_req = 1'b1; bus.data_addr_ok = 1'b1;
        #1;
        chk1 ("t5_req_blk", bus.data_req, 1'b0);
        chk1 ("t5_stall", mem_stall, 1'b1);
        mem_req = 1'b0; bus.data_addr_ok = 1'b0; wb_ready = 1'b1;
        nxt();
        #1;
        chk1 ("t5_valid2", wb_rdata_valid, 1'b1);
        chk32("t5_second", wb_rdata, 32'h2);
        nxt();
        #1 chk1("t5_empty", wb_rdata_valid, 1'b0);

        // Reset with cnt=1 and rbuf_cnt=1, then a stray response
        wb_ready = 1'b0;
        nxt();
        mem_req = 1'b1; bus.data_addr_ok = 1'b1;
        nxt();
        nxt();
        mem_req = 1'b0; bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_5555;
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t6_valid_pre", wb_rdata_valid, 1'b1);
        chk1 ("t6_idle_pre", idle, 1'b0);
        rst = 1'b1;
        #1;
        chk1 ("t6_valid_rst", wb_rdata_valid, 1'b0);
        chk1 ("t6_idle_rst", idle, 1'b1);
        chk1 ("t6_req_rst", bus.data_req, 1'b0);
        chk1 ("t6_stall_rst", mem_stall, 1'b0);
        chk32("t6_rdata_rst", wb_rdata, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h6666_6666;
        #1;
        chk1 ("t6_stray_valid", wb_rdata_valid, 1'b0);
        chk1 ("t6_stray_idle", idle, 1'b1);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk1 ("t6_after_valid", wb_rdata_valid, 1'b0);
        chk1 ("t6_after_idle", idle, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            mem_req          = ($urandom % 4) != 0;
            mem_wr           = ($urandom % 3) == 0;
            mem_size         = 2'($urandom % 3);
            mem_addr         = $urandom;
            mem_wdata        = $urandom;
            flush            = ($urandom % 16) == 0;
            bus.data_addr_ok = ($urandom % 4) != 0;
            bus.data_data_ok = (tagq.size() != 0) && (($urandom % 2) == 1);
            bus.data_rdata   = $urandom;
            wb_ready         = ($urandom % 3) != 0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_load_ctrl.md
Name: wb_load_ctrl

Overview:
- Controls the data-side SRAM-like bus between the MEM stage request and the WB-stage load-data path.
- Issues MEM-stage requests to the bus and tracks outstanding transactions in order.
- Discards write and flushed responses; buffers returned read data until WB accepts it.
- Produces the MEM stall and the WB read-data handshake that feeds WB sign/zero extension and the forwarding mux.

Parameters:
- MAX_OUT, 2, maximum accepted-but-unanswered bus transactions (1..4).
- RBUF_DEPTH, 2, return-data buffer entries; must be >= MAX_OUT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  in  1  MEM stage has a valid load/store this cycle
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 = word
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data
- mem_stall  out  1  MEM must hold its request
- flush  in  1  exception/eret flush of MEM/WB
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  bus accepted request
- data_data_ok  in  1  bus response valid
- data_rdata  in  32  bus read data
- wb_ready  in  1  WB consumes read data this cycle
- wb_rdata_valid  out  1  wb_rdata holds valid load data
- wb_rdata  out  32  oldest buffered load data
- idle  out  1  no outstanding transactions and return buffer empty

Behaviour:
- Reset (async, rst=1):
  - cnt=0, tag FIFO empty, return buffer empty, wb_rdata=0.
  - data_req=0, wb_rdata_valid=0, mem_stall=0, idle=1.
- Issue gate: can_issue = cnt<MAX_OUT && (mem_wr || cnt+rbuf_cnt<RBUF_DEPTH).
  - This guarantees the return buffer never overflows.
- data_req = mem_req && !flush && can_issue.
- data_wr/size/addr/wdata pass combinationally from mem_*.
- accept = data_req && data_addr_ok.
- mem_stall = mem_req && !flush && !accept.
- Tag FIFO (depth MAX_OUT, in order):
  - Each accept pushes {wr=mem_wr, kill=0}.
  - Each data_data_ok pops the head.
- cnt update:
  - +1 on accept, -1 on data_data_ok.
  - Accept and data_ok in the same cycle: cnt unchanged; push and pop both occur.
- Response routing on data_data_ok:
  - Head wr=1 or kill=1: response dropped.
  - Otherwise data_rdata is written to the return buffer tail.
- data_data_ok with cnt==0: ignored, no underflow; flagged by a simulation assertion.
- flush:
  - Sets kill on every tag FIFO entry, including one popped in the same cycle, whose data is dropped.
  - Empties the return buffer and blocks issue that cycle.
  - cnt is not cleared: killed responses still drain from the bus.
- Return buffer (circular, RBUF_DEPTH):
  - wb_rdata_valid = rbuf_cnt!=0; wb_rdata = head entry.
  - Pop when wb_rdata_valid && wb_ready.
  - Simultaneous push and pop: rbuf_cnt unchanged.
  - Pointers wrap modulo RBUF_DEPTH.
- Latency without the optional feature: data_data_ok in cycle N gives wb_rdata_valid in cycle N+1.
- idle = cnt==0 && rbuf_cnt==0.
- Reset mid-transaction: all state cleared immediately. The surrounding SoC resets the bus in the same cycle, so no stale responses arrive.

Optional Feature:
- Macro: WB_RDATA_BYPASS_EN.
- Defined:
  - When the return buffer is empty and an unkilled read response arrives, wb_rdata_valid=1 and wb_rdata=data_rdata combinationally in cycle N.
  - If wb_ready=1 that cycle, the data is not written to the buffer; otherwise it is buffered as normal.
  - Load-use latency is reduced by one cycle.
- Undefined: all read data passes through the buffer with 1-cycle latency; no combinational path from data_rdata to wb_rdata.

Test Plan:
- Single load, addr 0x80001000, size 2, addr_ok on first cycle, data_ok 2 cycles later with 0xDEADBEEF, wb_ready=1:
  - mem_stall=0; cnt 0->1->0.
  - wb_rdata=0xDEADBEEF valid for one cycle, 1 cycle after data_ok (0 with bypass).
  - idle returns to 1.
- Store then load back-to-back, data_ok responses 0x11111111 then 0x22222222:
  - Only 0x22222222 reaches wb_rdata; store response dropped.
- MAX_OUT=2, three loads with addr_ok held 1 and data_ok withheld:
  - Third request sees data_req=0 and mem_stall=1 until the first data_ok.
- Two outstanding loads, flush asserted, then both data_ok (0xAAAA0000, 0xBBBB0000):
  - wb_rdata_valid stays 0; cnt drains to 0; flush cycle has data_req=0.
- wb_ready=0 with two loads returning 0x1, 0x2:
  - Buffer holds both; the next load is blocked (cnt+rbuf_cnt=2).
  - Raising wb_ready yields 0x1 then 0x2 in order on consecutive cycles.
- rst pulsed while cnt=1 and rbuf_cnt=1:
  - Outputs return to reset values asynchronously.
  - A later data_data_ok with cnt==0 is ignored.
